// File: rtl/lcd_pkg.sv
// lcd_pkg: shared defaults, tag values and FSM encoding for the LCD/SDRAM arbiter.
package lcd_pkg;
  localparam int DEF_ADDR_WIDTH = 23;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LINE_WORDS = 640;
  localparam int DEF_MAX_DISP_RUN = 16;
  localparam int DEF_TAG_DEPTH = 4;
  localparam logic TAG_DISP = 1'b0;
  localparam logic TAG_HOST = 1'b1;
  typedef enum logic [1:0] {IDLE, DISP, HOST} state_t;
endpackage

// File: rtl/lcd_sdram_arbiter_if.sv
// lcd_sdram_arbiter_if: SDRAM command/read-return bus between arbiter and controller.
interface lcd_sdram_arbiter_if import lcd_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] q;
  logic we;
  logic req;
  logic ack;
  logic valid;
  modport master (output addr, data, we, req, input ack, valid, q);
  modport slave (input addr, data, we, req, output ack, valid, q);
endinterface

// File: rtl/tag_fifo.sv
// tag_fifo: 1-bit FIFO recording the owner of each outstanding SDRAM read.
module tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] mem;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      end
      if (do_pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/lcd_sdram_arbiter.sv
// lcd_sdram_arbiter: shares one SDRAM port between a display line fetcher and a host port.
module lcd_sdram_arbiter import lcd_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int MAX_DISP_RUN = DEF_MAX_DISP_RUN,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_req,
  input  logic [ADDR_WIDTH-1:0] line_base,
  output logic                  line_busy,
  output logic                  line_done,
  output logic                  line_err,
  output logic                  fill_valid,
  output logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  h_req,
  input  logic                  h_we,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [DATA_WIDTH-1:0] h_data,
  output logic                  h_ack,
  output logic                  h_valid,
  output logic [DATA_WIDTH-1:0] h_q,
  output logic                  tag_err,
  lcd_sdram_arbiter_if.master   sd
);
  localparam int CW = $clog2(LINE_WORDS + 1);
  state_t state;
  logic busy_r, full, empty, pop_tag, push, pop, disp_ok, host_ok, go_host;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [CW-1:0] issued, delivered, run;
  tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din(state == HOST ? TAG_HOST : TAG_DISP), .dout(pop_tag), .full(full), .empty(empty)
  );
  assign push = sd.ack & (state == DISP | (state == HOST & ~sd.we));
  assign pop = sd.valid;
  assign h_ack = ~rst & sd.ack & (state == HOST);
  assign fill_valid = ~rst & sd.valid & ~empty & (pop_tag == TAG_DISP);
  assign h_valid = ~rst & sd.valid & ~empty & (pop_tag == TAG_HOST);
  assign fill_data = fill_valid ? sd.q : '0;
  assign h_q = h_valid ? sd.q : '0;
  assign tag_err = ~rst & sd.valid & empty;
  // busy drops in the same cycle the last word is handed to the display
  assign line_done = fill_valid & busy_r & (delivered == CW'(LINE_WORDS - 1));
  assign line_busy = busy_r & ~line_done;
  assign line_err = ~rst & line_req & line_busy;
  assign disp_ok = busy_r & (issued != CW'(LINE_WORDS)) & ~full;
  assign host_ok = h_req & (h_we | ~full);
  assign go_host = host_ok & ((int'(run) >= MAX_DISP_RUN) | ~disp_ok);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sd.req <= 1'b0;
      sd.we <= 1'b0;
      sd.addr <= '0;
      sd.data <= '0;
      busy_r <= 1'b0;
      issue_addr <= '0;
      issued <= '0;
      delivered <= '0;
      run <= '0;
    end else begin
      case (state)
        IDLE: if (go_host) begin
          state <= HOST;
          sd.req <= 1'b1;
          sd.we <= h_we;
          sd.addr <= h_addr;
          sd.data <= h_data;
          run <= '0;
        end else if (disp_ok) begin
          state <= DISP;
          sd.req <= 1'b1;
          sd.we <= 1'b0;
          sd.addr <= issue_addr;
        end
        DISP: if (sd.ack) begin
          state <= IDLE;
          sd.req <= 1'b0;
          issue_addr <= issue_addr + 1'b1;
          issued <= issued + 1'b1;
          run <= run + 1'b1;
        end
        HOST: if (sd.ack) begin
          state <= IDLE;
          sd.req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (line_req & ~line_busy) begin
        busy_r <= 1'b1;
        issue_addr <= line_base;
        issued <= '0;
        delivered <= '0;
        run <= '0;
      end else begin
        if (line_done) busy_r <= 1'b0;
        if (fill_valid) delivered <= delivered + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lcd_sdram_arbiter.sv
// tb_lcd_sdram_arbiter: directed scoreboard bench with a fixed-latency SDRAM model.
module tb_lcd_sdram_arbiter;
  localparam int LW = 8;
  localparam int TD = 4;
  typedef struct {int due; logic [31:0] d;} rd_t;
  logic clk, rst, line_req, line_busy, line_done, line_err, fill_valid;
  logic h_req, h_we, h_ack, h_valid, tag_err;
  logic [22:0] line_base, h_addr;
  logic [31:0] fill_data, h_data, h_q;
  int checks = 0, failures = 0;
  int cyc = 0, lat = 3, stray_cnt = 0, stray_sent = 0, full_req = 0, max_out = 0;
  int n_done = 0, n_err = 0, n_terr = 0, n_hack = 0, fi = 0, hi = 0, ci = 0;
  rd_t pend[$];
  logic [31:0] obs_fill[$], obs_hq[$], wr_log[$], exp_fill[$], exp_hq[$];
  logic [23:0] cmd_log[$], exp_cmd[$];
  lcd_sdram_arbiter_if #(.ADDR_WIDTH(23), .DATA_WIDTH(32)) sd ();
  lcd_sdram_arbiter #(
    .ADDR_WIDTH(23), .DATA_WIDTH(32), .LINE_WORDS(LW), .MAX_DISP_RUN(4), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst), .line_req(line_req), .line_base(line_base), .line_busy(line_busy),
    .line_done(line_done), .line_err(line_err), .fill_valid(fill_valid), .fill_data(fill_data),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_data(h_data), .h_ack(h_ack),
    .h_valid(h_valid), .h_q(h_q), .tag_err(tag_err), .sd(sd)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend.delete();
      sd.ack = 1'b0;
      sd.valid = 1'b0;
      sd.q = '0;
    end else begin
      sd.ack = sd.req;
      if (sd.ack) begin
        cmd_log.push_back({sd.we, sd.addr});
        if (sd.we) wr_log.push_back(sd.data);
        else begin
          if (pend.size() >= TD) full_req++;
          pend.push_back('{due: cyc + lat, d: 32'hA500_0000 ^ {9'd0, sd.addr}});
          if (pend.size() > max_out) max_out = pend.size();
        end
      end
      if (stray_sent != stray_cnt) begin
        sd.valid = 1'b1;
        sd.q = 32'hDEAD_BEEF;
        stray_sent++;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        sd.valid = 1'b1;
        sd.q = pend[0].d;
        void'(pend.pop_front());
      end else begin
        sd.valid = 1'b0;
        sd.q = '0;
      end
    end
    #1;
    if (fill_valid) obs_fill.push_back(fill_data);
    if (h_valid) obs_hq.push_back(h_q);
    if (line_done) n_done++;
    if (line_err) n_err++;
    if (tag_err) n_terr++;
    if (h_ack) n_hack++;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, 64'(|{sd.req, sd.we, sd.addr, sd.data, h_ack, h_valid, h_q, fill_valid, fill_data,
                   line_busy, line_done, line_err, tag_err}), 64'd0);
  endtask
  task automatic line_start(input logic [22:0] base, input bit expect_fill);
    if (expect_fill) for (int i = 0; i < LW; i++) exp_fill.push_back(32'hA500_0000 ^ {9'd0, base + 23'(i)});
    @(posedge clk); #1 line_req = 1'b1; line_base = base;
    @(posedge clk); #1 line_req = 1'b0;
    chk("line_busy_rise", 64'(line_busy), 64'd1);
  endtask
  task automatic exp_line_cmds(input logic [22:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) exp_cmd.push_back({1'b0, base + 23'(i)});
  endtask
  task automatic wait_done(input string tag, input int d0, input int bound);
    for (int i = 0; i < bound && n_done == d0; i++) @(posedge clk);
    #2;
    chk(tag, 64'(n_done), 64'(d0 + 1));
    chk({tag, "_busy_low"}, 64'(line_busy), 64'd0);
  endtask
  task automatic wait_hack(input string tag, input int h0);
    for (int i = 0; i < 200 && n_hack == h0; i++) @(posedge clk);
    chk(tag, 64'(n_hack), 64'(h0 + 1));
    #1 h_req = 1'b0; h_we = 1'b0;
  endtask
  task automatic check_fill(input string tag);
    while (exp_fill.size() > 0) begin
      chk(tag, fi < obs_fill.size() ? obs_fill[fi] : 32'hx, exp_fill.pop_front());
      fi++;
    end
    chk({tag, "_count"}, 64'(obs_fill.size()), 64'(fi));
  endtask
  task automatic check_cmds(input string tag);
    while (exp_cmd.size() > 0) begin
      chk(tag, ci < cmd_log.size() ? cmd_log[ci] : 24'hx, exp_cmd.pop_front());
      ci++;
    end
    chk({tag, "_count"}, 64'(cmd_log.size()), 64'(ci));
  endtask
  initial begin
    int d0, e0, t0, f0, c0;
    rst = 1'b1; line_req = 1'b0; line_base = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_data = '0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_outputs");
    rst = 1'b0;
    // basic line fetch, 3-cycle latency
    lat = 3; d0 = n_done;
    exp_line_cmds(23'h100, 0, LW - 1);
    line_start(23'h100, 1'b1);
    wait_done("t1_done", d0, 300);
    check_fill("t1_fill");
    check_cmds("t1_cmd");
    // host read held from first display grant wins after 4 display acks
    d0 = n_done;
    exp_line_cmds(23'h200, 0, 3);
    exp_cmd.push_back({1'b0, 23'h1234});
    exp_line_cmds(23'h200, 4, LW - 1);
    exp_hq.push_back(32'hA500_0000 ^ 32'h1234);
    line_start(23'h200, 1'b1);
    for (int i = 0; i < 50 && !sd.req; i++) @(posedge clk) #1;
    h_req = 1'b1; h_we = 1'b0; h_addr = 23'h1234;
    wait_hack("t2_hack", n_hack);
    wait_done("t2_done", d0, 300);
    check_fill("t2_fill");
    check_cmds("t2_cmd");
    while (exp_hq.size() > 0) begin
      chk("t2_hq", hi < obs_hq.size() ? obs_hq[hi] : 32'hx, exp_hq.pop_front());
      hi++;
    end
    // host write with no line active, then a stray valid
    exp_cmd.push_back({1'b1, 23'h55AA55});
    t0 = wr_log.size();
    @(posedge clk); #1 h_req = 1'b1; h_we = 1'b1; h_addr = 23'h55AA55; h_data = 32'h55AA55AA;
    wait_hack("t3_hack", n_hack);
    repeat (5) @(posedge clk);
    #2 chk("t3_wr_count", 64'(wr_log.size()), 64'(t0 + 1));
    chk("t3_wr_data", wr_log[wr_log.size() - 1], 64'h55AA55AA);
    check_cmds("t3_cmd");
    t0 = n_terr; f0 = obs_fill.size();
    stray_cnt++;
    repeat (4) @(posedge clk);
    #2 chk("t3_tag_err", 64'(n_terr), 64'(t0 + 1));
    chk("t3_no_hvalid", 64'(obs_hq.size()), 64'(hi));
    chk("t3_no_fill", 64'(obs_fill.size()), 64'(f0));
    // long latency: tag FIFO limits outstanding reads
    lat = 20; d0 = n_done;
    exp_line_cmds(23'h300, 0, LW - 1);
    line_start(23'h300, 1'b1);
    wait_done("t4_done", d0, 1000);
    chk("t4_max_out", 64'(max_out), 64'(TD));
    chk("t4_req_while_full", 64'(full_req), 64'd0);
    check_fill("t4_fill");
    check_cmds("t4_cmd");
    // line_req while busy is flagged and ignored
    lat = 3; d0 = n_done; e0 = n_err;
    exp_line_cmds(23'h400, 0, LW - 1);
    line_start(23'h400, 1'b1);
    repeat (6) @(posedge clk);
    #1 line_req = 1'b1; line_base = 23'h999;
    #2 chk("t5_err_high", 64'(line_err), 64'd1);
    @(posedge clk); #1 line_req = 1'b0; line_base = '0;
    #2 chk("t5_err_low", 64'(line_err), 64'd0);
    wait_done("t5_done", d0, 300);
    chk("t5_err_count", 64'(n_err), 64'(e0 + 1));
    check_fill("t5_fill");
    check_cmds("t5_cmd");
    // reset mid-line abandons it; a later stray valid only raises tag_err
    d0 = n_done; c0 = cmd_log.size();
    line_start(23'h500, 1'b0);
    for (int i = 0; i < 100 && cmd_log.size() < c0 + 3; i++) @(posedge clk);
    chk("t6_three_acks", 64'(cmd_log.size()), 64'(c0 + 3));
    #1 rst = 1'b1;
    f0 = obs_fill.size();
    @(posedge clk);
    #1 chk_zero("t6_reset_outputs");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    t0 = n_terr;
    stray_cnt++;
    repeat (6) @(posedge clk);
    #2 chk("t6_tag_err", 64'(n_terr), 64'(t0 + 1));
    chk("t6_no_fill", 64'(obs_fill.size()), 64'(f0));
    chk("t6_no_done", 64'(n_done), 64'(d0));
    chk("t6_idle", 64'({line_busy, sd.req}), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
